key_direction_ctrl: RTL and testbench



---
 rtl/key_direction_ctrl_if.sv | 25 ++
 rtl/key_direction_ctrl.sv | 139 +++++++++++++
 tb/tb_key_direction_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/key_direction_ctrl_if.sv
// Key inputs and counter-control outputs of key_direction_ctrl.
// master drives the raw buttons; slave is the control block itself.
interface key_direction_ctrl_if;
    logic key_dir_n;
    logic key_ctl_n;
    logic direction;
    logic hold;
    logic clear;

    modport master (
        output key_dir_n,
        output key_ctl_n,
        input  direction,
        input  hold,
        input  clear
    );

    modport slave (
        input  key_dir_n,
        input  key_ctl_n,
        output direction,
        output hold,
        output clear
    );
endinterface

// File: rtl/key_direction_ctrl.sv
// Debounces the direction and control buttons of the up/down counter and
// turns them into a direction level, a hold level and a one-cycle clear pulse.
module key_direction_ctrl #(
    parameter int DEB_CYC  = 20000,
    parameter int LONG_CYC = 1000000,
    parameter int CNT_W    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    key_direction_ctrl_if.slave bus
);
    typedef enum logic [1:0] {UP, DEB_DOWN, DOWN, DEB_UP} key_st_e;

    localparam int KDIR = 0;
    localparam int KCTL = 1;
    // Transitions fire on the edge where the counter reaches its last value,
    // so the comparison is against the value one below it.
    localparam logic [CNT_W-1:0] DEB_PEN  = CNT_W'(DEB_CYC - 2);
    localparam logic [CNT_W-1:0] LONG_PEN = CNT_W'(LONG_CYC - 2);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYC);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == LONG_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    key_st_e          st      [2];
    key_st_e          st_nxt  [2];
    logic [CNT_W-1:0] cnt     [2];
    logic [CNT_W-1:0] cnt_nxt [2];
    logic [1:0]       press_evt;
    logic [1:0]       release_evt;
    logic [CNT_W-1:0] lcnt;
    logic             long_done;
    logic             ctl_held;
    logic             long_hit;
    logic             dir_q;
    logic             hold_q;
    logic             clear_q;

    // stage p0/p1: two-flop synchronizer, bit 0 = direction key, bit 1 = control key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= {bus.key_ctl_n, bus.key_dir_n};
            sync_p1 <= sync_p0;
        end
    end

    // debounce FSMs, one per key, fed from the synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                st[k]  <= UP;
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                st[k]  <= st_nxt[k];
                cnt[k] <= cnt_nxt[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            st_nxt[k]      = st[k];
            cnt_nxt[k]     = '0;
            press_evt[k]   = 1'b0;
            release_evt[k] = 1'b0;
            case (st[k])
                UP: begin
                    if (!sync_p1[k]) st_nxt[k] = DEB_DOWN;
                end
                DEB_DOWN: begin
                    if (sync_p1[k]) begin
                        st_nxt[k] = UP;
                    end else if (cnt[k] == DEB_PEN) begin
                        st_nxt[k]    = DOWN;
                        press_evt[k] = 1'b1;
                    end else begin
                        cnt_nxt[k] = cnt[k] + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (sync_p1[k]) st_nxt[k] = DEB_UP;
                end
                DEB_UP: begin
                    if (!sync_p1[k]) begin
                        st_nxt[k] = DOWN;
                    end else if (cnt[k] == DEB_PEN) begin
                        st_nxt[k]      = UP;
                        release_evt[k] = 1'b1;
                    end else begin
                        cnt_nxt[k] = cnt[k] + CNT_W'(1);
                    end
                end
                default: st_nxt[k] = UP;
            endcase
        end
    end

    assign ctl_held = (st[KCTL] == DOWN) || (st[KCTL] == DEB_UP);
    assign long_hit = ctl_held && !long_done && (lcnt == LONG_PEN);

    // output stage: direction/hold levels, clear pulse and long-press tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= 1'b1;
            hold_q    <= 1'b0;
            clear_q   <= 1'b0;
            lcnt      <= '0;
            long_done <= 1'b0;
        end else begin
            clear_q <= long_hit;
            if (press_evt[KDIR]) dir_q <= ~dir_q;
            if (press_evt[KCTL]) begin
                lcnt      <= '0;
                long_done <= 1'b0;
            end else if (ctl_held) begin
                lcnt <= sat_inc(lcnt);
                if (long_hit) long_done <= 1'b1;
            end
            // a long press wins over a release landing on the same edge
            if (long_hit) begin
                hold_q <= 1'b0;
            end else if (release_evt[KCTL] && !long_done) begin
                hold_q <= ~hold_q;
            end
        end
    end

    assign bus.direction = dir_q;
    assign bus.hold      = hold_q;
    assign bus.clear     = clear_q;
endmodule

// File: tb/tb_key_direction_ctrl.sv
// Directed bench for key_direction_ctrl: expected output changes are queued
// with their cycle stamp as stimulus is driven and matched by a monitor.
module tb_key_direction_ctrl;
    localparam int DEB  = 8;
    localparam int LONG = 40;
    localparam logic [1:0] KDIR  = 2'd0;
    localparam logic [1:0] KHOLD = 2'd1;
    localparam logic [1:0] KCLR  = 2'd2;

    typedef struct packed {
        int         cyc;
        logic [1:0] kind;
        logic       val;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];
    logic prev_dir;
    logic prev_hold;

    key_direction_ctrl_if bus ();

    key_direction_ctrl #(
        .DEB_CYC (DEB),
        .LONG_CYC(LONG),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input logic [1:0] k);
        case (k)
            KDIR:    return "direction";
            KHOLD:   return "hold";
            default: return "clear";
        endcase
    endfunction

    task automatic expect_ev(input int c, input logic [1:0] k, input logic v);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic log_event(input logic [1:0] k, input logic v);
        ev_t obs;
        ev_t exp;
        obs.cyc  = cyc;
        obs.kind = k;
        obs.val  = v;
        if (sb.size() != 0) begin
            exp = sb.pop_front();
        end else begin
            exp.cyc  = -1;
            exp.kind = k;
            exp.val  = v;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL event: observed %s=%b at cycle %0d, expected %s=%b at cycle %0d",
                   kind_name(obs.kind), obs.val, obs.cyc,
                   kind_name(exp.kind), exp.val, exp.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dir  = bus.direction;
            prev_hold = bus.hold;
        end else begin
            if (bus.direction !== prev_dir) log_event(KDIR, bus.direction);
            if (bus.hold !== prev_hold)     log_event(KHOLD, bus.hold);
            if (bus.clear !== 1'b0)         log_event(KCLR, bus.clear);
            prev_dir  = bus.direction;
            prev_hold = bus.hold;
        end
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit({tag, "_direction"}, bus.direction, 1'b1);
        check_bit({tag, "_hold"}, bus.hold, 1'b0);
        check_bit({tag, "_clear"}, bus.clear, 1'b0);
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n         = 1'b1;
        bus.key_dir_n = 1'b1;
        bus.key_ctl_n = 1'b1;

        // Asynchronous reset mid-cycle, outputs checked before any clock edge
        #7 rst_n = 1'b0;
        #1;
        check_bit("reset_direction", bus.direction, 1'b1);
        check_bit("reset_hold", bus.hold, 1'b0);
        check_bit("reset_clear", bus.clear, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(5);

        // Clean direction presses; a 200-cycle hold toggles only once
        t = cyc; bus.key_dir_n = 1'b0; expect_ev(t + 10, KDIR, 1'b0);
        idle(20); bus.key_dir_n = 1'b1; idle(15);
        t = cyc; bus.key_dir_n = 1'b0; expect_ev(t + 10, KDIR, 1'b1);
        idle(200); bus.key_dir_n = 1'b1; idle(15);

        // Bounce: low 5, high 2, low 5, then high; no toggle expected
        bus.key_dir_n = 1'b0; idle(5);
        bus.key_dir_n = 1'b1; idle(2);
        bus.key_dir_n = 1'b0; idle(5);
        bus.key_dir_n = 1'b1; idle(15);
        t = cyc; bus.key_dir_n = 1'b0; expect_ev(t + 10, KDIR, 1'b0);
        idle(10); bus.key_dir_n = 1'b1; idle(15);

        // Short control presses toggle hold on release
        bus.key_ctl_n = 1'b0; idle(20);
        t = cyc; bus.key_ctl_n = 1'b1; expect_ev(t + 10, KHOLD, 1'b1);
        idle(15);
        bus.key_ctl_n = 1'b0; idle(20);
        t = cyc; bus.key_ctl_n = 1'b1; expect_ev(t + 10, KHOLD, 1'b0);
        idle(15);

        // Long press with hold=1: one clear pulse, hold drops, release keeps it
        bus.key_ctl_n = 1'b0; idle(20);
        t = cyc; bus.key_ctl_n = 1'b1; expect_ev(t + 10, KHOLD, 1'b1);
        idle(15);
        t = cyc; bus.key_ctl_n = 1'b0;
        expect_ev(t + 10 + LONG - 1, KHOLD, 1'b0);
        expect_ev(t + 10 + LONG - 1, KCLR, 1'b1);
        idle(100); bus.key_ctl_n = 1'b1; idle(15);

        // Both keys together: direction on press, hold only on release
        t = cyc; bus.key_dir_n = 1'b0; bus.key_ctl_n = 1'b0;
        expect_ev(t + 10, KDIR, 1'b1);
        idle(20);
        t = cyc; bus.key_dir_n = 1'b1; bus.key_ctl_n = 1'b1;
        expect_ev(t + 10, KHOLD, 1'b1);
        idle(15);
        t = cyc; bus.key_dir_n = 1'b0; expect_ev(t + 10, KDIR, 1'b0);
        idle(20); bus.key_dir_n = 1'b1; idle(15);

        // Reset during DEB_DOWN of the control key; short hold after release
        bus.key_ctl_n = 1'b0; idle(5);
        async_reset_check("midpress_reset");
        idle(5); bus.key_ctl_n = 1'b1; idle(20);

        // Reset mid-press, key kept down long enough to re-debounce
        bus.key_ctl_n = 1'b0; idle(5);
        async_reset_check("redebounce_reset");
        idle(20);
        t = cyc; bus.key_ctl_n = 1'b1; expect_ev(t + 10, KHOLD, 1'b1);
        idle(20);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL pending_events: observed %0d outstanding, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
